// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter in front of the BRAM controller's native bus.
// Optional watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for a master request; arbitration happens here
// ACTIVE | latched request presented to the slave, waiting for s_ready
// RESP   | one-cycle ready pulse with captured rdata to the owner
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        grant,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        owner;
  logic        last_grant;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] rdata_q;
  logic        req_any;
  logic        req_sel;
  logic        expire;

  // On a tie the master that did not win last time gets the bus.
  always_comb begin
    req_any = m0_valid | m1_valid;
    if (m0_valid && m1_valid) req_sel = ~last_grant;
    else                      req_sel = m1_valid;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (req_any) state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (s_ready || expire) state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner      <= 1'b0;
      last_grant <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
    end else begin
      if (state == ST_IDLE && req_any) begin
        owner      <= req_sel;
        last_grant <= req_sel;
        addr_q     <= req_sel ? m1_addr  : m0_addr;
        wdata_q    <= req_sel ? m1_wdata : m0_wdata;
        wstrb_q    <= req_sel ? m1_wstrb : m0_wstrb;
      end
      // A real s_ready wins over a watchdog expiry in the same cycle.
      if (state == ST_ACTIVE && s_ready)
        rdata_q <= s_rdata;
      else if (expire)
        rdata_q <= 32'hDEAD_BEEF;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt;
  logic        tmo_err_q;

  assign expire = (state == ST_ACTIVE) && !s_ready &&
                  (wd_cnt == 16'(TIMEOUT_CYCLES - 1));

  // Held at zero outside ACTIVE so it starts clean on every transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt    <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      if (state != ST_ACTIVE)  wd_cnt <= '0;
      else if (!s_ready)       wd_cnt <= wd_cnt + 16'd1;
      if (expire) tmo_err_q <= 1'b1;
    end
  end

  assign timeout_err = tmo_err_q;
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Outputs decode registers only; no master-to-slave combinational path.
  always_comb begin
    s_valid  = (state == ST_ACTIVE);
    s_addr   = addr_q;
    s_wdata  = wdata_q;
    s_wstrb  = wstrb_q;
    m0_ready = (state == ST_RESP) && !owner;
    m1_ready = (state == ST_RESP) &&  owner;
    m0_rdata = rdata_q;
    m1_rdata = rdata_q;
    grant    = owner;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter with a small BRAM-controller model.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic        grant, timeout_err;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(grant), .timeout_err(timeout_err)
  );

  // BRAM controller model: ready after wait_cycles cycles of s_valid.
  logic [31:0] mem [0:2047];
  int          wait_cycles = 3;
  int          bcnt;

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'h1000_0000 + i;
    mem[1] = 32'h1234_5678;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      s_ready <= 1'b0;
      s_rdata <= '0;
      bcnt    <= 0;
    end else if (s_ready) begin
      s_ready <= 1'b0;
      bcnt    <= 0;
    end else if (s_valid) begin
      if (bcnt >= wait_cycles - 1) begin
        s_ready <= 1'b1;
        s_rdata <= mem[s_addr[12:2]];
        if (s_wstrb == 4'hF) mem[s_addr[12:2]] <= s_wdata;
        bcnt    <= 0;
      end else begin
        bcnt <= bcnt + 1;
      end
    end else begin
      bcnt <= 0;
    end
  end

  typedef struct {
    logic        who;
    logic        chk;
    logic [31:0] data;
    logic        tmo;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   n_rdy0 = 0;
  int   n_rdy1 = 0;
  int   vcnt = 0;
  logic prev_hs = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per ready pulse.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      vcnt    = 0;
      prev_hs = 1'b0;
    end else begin
      if (m0_ready || m1_ready) begin
        check("single_ready", 32'(m0_ready & m1_ready), 32'd0);
        if (sbq.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_ready: got m0=%0b m1=%0b expected none", m0_ready, m1_ready);
        end else begin
          e = sbq.pop_front();
          check("ready_owner", 32'(m1_ready), 32'(e.who));
          check("grant", 32'(grant), 32'(e.who));
          if (e.chk) check("rdata", e.who ? m1_rdata : m0_rdata, e.data);
          if (e.tmo) check("tmo_active_cycles", vcnt, 8);
          else       check("ready_after_s_ready", 32'(prev_hs), 32'd1);
        end
        if (m0_ready) n_rdy0++;
        if (m1_ready) n_rdy1++;
        vcnt = 0;
      end
      if (s_valid) vcnt++;
      prev_hs = s_valid && s_ready;
    end
  end

  task automatic xfer(input bit who, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input bit keep);
    int t = 0;
    bit got = 0;
    if (who) begin
      m1_valid = 1'b1; m1_addr = a; m1_wdata = d; m1_wstrb = s;
    end else begin
      m0_valid = 1'b1; m0_addr = a; m0_wdata = d; m0_wstrb = s;
    end
    while (!got && t < 1000) begin
      @(posedge clk); #1;
      t++;
      got = who ? m1_ready : m0_ready;
    end
    if (!got) begin
      n_vec++;
      n_miss++;
      $display("FAIL xfer_timeout: got no ready from m%0d expected ready within 1000 cycles", who);
    end
    @(posedge clk); #1;
    if (!keep || !got) begin
      if (who) m1_valid = 1'b0;
      else     m0_valid = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish before 500us");
    $fatal(1);
  end

  initial begin
    int r0, r1;
    reset    = 1'b1;
    m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_valid", 32'(s_valid), 32'd0);
    check("rst_m0_ready", 32'(m0_ready), 32'd0);
    check("rst_m1_ready", 32'(m1_ready), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_s_addr", s_addr, 32'd0);
    check("rst_rdata", m0_rdata, 32'd0);
    reset = 1'b0;

    // m0 read of word 1
    sbq.push_back('{1'b0, 1'b1, 32'h1234_5678, 1'b0});
    fork
      xfer(1'b0, 32'h4, 32'h0, 4'h0, 1'b0);
      begin
        @(posedge clk); #2;
        check("s_valid_latency", 32'(s_valid), 32'd1);
        check("s_addr", s_addr, 32'h4);
        check("s_wstrb", 32'(s_wstrb), 32'd0);
      end
    join

    // m1 write then m0 readback
    sbq.push_back('{1'b1, 1'b0, 32'h0, 1'b0});
    xfer(1'b1, 32'h10, 32'hCAFE_F00D, 4'hF, 1'b0);
    sbq.push_back('{1'b0, 1'b1, 32'hCAFE_F00D, 1'b0});
    xfer(1'b0, 32'h10, 32'h0, 4'h0, 1'b0);

    // both pending from reset: strict alternation 0,1,0,1
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    r0 = n_rdy0;
    r1 = n_rdy1;
    sbq.push_back('{1'b0, 1'b1, 32'h1000_0008, 1'b0});
    sbq.push_back('{1'b1, 1'b1, 32'h1000_0009, 1'b0});
    sbq.push_back('{1'b0, 1'b1, 32'h1000_000A, 1'b0});
    sbq.push_back('{1'b1, 1'b1, 32'h1000_000B, 1'b0});
    fork
      begin
        xfer(1'b0, 32'h20, 32'h0, 4'h0, 1'b1);
        xfer(1'b0, 32'h28, 32'h0, 4'h0, 1'b0);
      end
      begin
        xfer(1'b1, 32'h24, 32'h0, 4'h0, 1'b1);
        xfer(1'b1, 32'h2C, 32'h0, 4'h0, 1'b0);
      end
    join
    check("m0_pulses", n_rdy0 - r0, 32'd2);
    check("m1_pulses", n_rdy1 - r1, 32'd2);

    // reset while ACTIVE, then an m1-only request
    @(posedge clk); #1;
    m0_valid = 1'b1; m0_addr = 32'h30; m0_wstrb = 4'h0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_s_valid", 32'(s_valid), 32'd0);
    check("midrst_m0_ready", 32'(m0_ready), 32'd0);
    check("midrst_grant", 32'(grant), 32'd0);
    check("midrst_s_addr", s_addr, 32'd0);
    check("midrst_rdata", m0_rdata, 32'd0);
    m0_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    sbq.push_back('{1'b1, 1'b1, 32'h1000_000D, 1'b0});
    xfer(1'b1, 32'h34, 32'h0, 4'h0, 1'b0);

`ifdef MEM_ARB_TIMEOUT_EN
    wait_cycles = 1000;
    sbq.push_back('{1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1});
    xfer(1'b0, 32'h4, 32'h0, 4'h0, 1'b0);
    check("tmo_err_set", 32'(timeout_err), 32'd1);
    wait_cycles = 3;
    sbq.push_back('{1'b1, 1'b1, 32'h1234_5678, 1'b0});
    xfer(1'b1, 32'h4, 32'h0, 4'h0, 1'b0);
    check("tmo_err_sticky", 32'(timeout_err), 32'd1);
`else
    wait_cycles = 200;
    sbq.push_back('{1'b0, 1'b1, 32'h1234_5678, 1'b0});
    xfer(1'b0, 32'h4, 32'h0, 4'h0, 1'b0);
    check("slow_no_tmo", 32'(timeout_err), 32'd0);
    wait_cycles = 3;
`endif

    repeat (5) @(posedge clk);
    #1;
    check("queue_drained", sbq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
